// File: rtl/branch_resolve_update.sv
// Branch resolution buffer: detects mispredicts, redirects fetch,
// and replays resolved outcomes to the predictor at commit.
module branch_resolve_update #(
  parameter int DEPTH     = 8,
  parameter int ROB_IDX_W = 6
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   resolve_valid,
  output logic                   resolve_ready,
  input  logic [63:0]            resolve_pc,
  input  logic [ROB_IDX_W-1:0]   resolve_rob_idx,
  input  logic                   resolve_taken,
  input  logic [63:0]            resolve_target,
  input  logic                   pred_taken,
  input  logic [63:0]            pred_target,
  input  logic [ROB_IDX_W-1:0]   rob_head,
  input  logic                   commit_valid,
  input  logic [ROB_IDX_W-1:0]   commit_rob_idx,
  output logic                   redirect_valid,
  output logic [63:0]            redirect_pc,
  output logic [ROB_IDX_W-1:0]   redirect_rob_idx,
  output logic                   update_valid,
  output logic [63:0]            update_pc,
  output logic                   update_taken,
  output logic [63:0]            update_target,
  output logic [$clog2(DEPTH):0] occupancy,
  output logic [31:0]            mispredict_cnt
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  typedef logic [ROB_IDX_W-1:0] idx_t;

  logic [DEPTH-1:0] vld_q, vld_d;
  logic [63:0]      pc_q  [DEPTH];
  logic [63:0]      tg_q  [DEPTH];
  logic             tk_q  [DEPTH];
  idx_t             idx_q [DEPTH];
  idx_t             age_e [DEPTH];

  logic             fence_vld_q;
  idx_t             fence_idx_q;

  logic [CW-1:0]    occ;
  logic [PW-1:0]    free_sel;
  logic             cm_hit;
  logic [PW-1:0]    cm_sel;
  idx_t             res_age;
  idx_t             fen_age;
  logic             fenced;
  logic             mispred;
  logic             accept;
  logic             take;
  logic             mp;
  logic             fence_clr;

  // Occupancy is a popcount of registered valid bits only.
  always_comb begin
    occ = '0;
    for (int i = 0; i < DEPTH; i++) begin
      occ = occ + CW'(vld_q[i]);
    end
  end

  assign occupancy     = occ;
  assign resolve_ready = (occ != CW'(DEPTH));
  assign accept        = resolve_valid & resolve_ready;

  // Ages are ROB distances from head; larger means younger.
  always_comb begin
    for (int i = 0; i < DEPTH; i++) begin
      age_e[i] = idx_q[i] - rob_head;
    end
  end

  assign res_age = resolve_rob_idx - rob_head;
  assign fen_age = fence_idx_q - rob_head;
  assign fenced  = fence_vld_q & (res_age > fen_age);

  assign mispred = (resolve_taken != pred_taken) |
                   (resolve_taken & pred_taken &
                    (resolve_target != pred_target));

  assign take      = accept & ~fenced;
  assign mp        = take & mispred;
  assign fence_clr = commit_valid & fence_vld_q &
                     (commit_rob_idx == fence_idx_q);

  // Lowest-numbered free slot, and commit CAM over pre-edge contents.
  always_comb begin
    free_sel = '0;
    cm_hit   = 1'b0;
    cm_sel   = '0;
    for (int i = DEPTH - 1; i >= 0; i--) begin
      if (!vld_q[i]) begin
        free_sel = PW'(i);
      end
      if (commit_valid && vld_q[i] &&
          idx_q[i] == commit_rob_idx) begin
        cm_hit = 1'b1;
        cm_sel = PW'(i);
      end
    end
  end

  // Next valid mask: free committed, squash younger, allocate new.
  always_comb begin
    vld_d = vld_q;
    if (cm_hit) begin
      vld_d[cm_sel] = 1'b0;
    end
    if (mp) begin
      for (int i = 0; i < DEPTH; i++) begin
        if (vld_q[i] && age_e[i] > res_age) begin
          vld_d[i] = 1'b0;
        end
      end
    end
    if (take) begin
      vld_d[free_sel] = 1'b1;
    end
  end

  // Entry storage holds the actual outcome of each buffered branch.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vld_q <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        pc_q[i]  <= '0;
        tg_q[i]  <= '0;
        tk_q[i]  <= 1'b0;
        idx_q[i] <= '0;
      end
    end else begin
      vld_q <= vld_d;
      if (take) begin
        pc_q[free_sel]  <= resolve_pc;
        tg_q[free_sel]  <= resolve_target;
        tk_q[free_sel]  <= resolve_taken;
        idx_q[free_sel] <= resolve_rob_idx;
      end
    end
  end

  // Fence tracks the oldest outstanding mispredict.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fence_vld_q <= 1'b0;
      fence_idx_q <= '0;
    end else if (mp) begin
      fence_vld_q <= 1'b1;
      fence_idx_q <= resolve_rob_idx;
    end else if (fence_clr) begin
      fence_vld_q <= 1'b0;
    end
  end

  // Registered redirect pulse and mispredict counter.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      redirect_valid   <= 1'b0;
      redirect_pc      <= '0;
      redirect_rob_idx <= '0;
      mispredict_cnt   <= '0;
    end else begin
      redirect_valid <= mp;
      if (mp) begin
        redirect_pc      <= resolve_taken ? resolve_target
                                          : resolve_pc + 64'd4;
        redirect_rob_idx <= resolve_rob_idx;
        mispredict_cnt   <= mispredict_cnt + 32'd1;
      end
    end
  end

  // Registered predictor training pulse on commit match.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      update_valid  <= 1'b0;
      update_pc     <= '0;
      update_taken  <= 1'b0;
      update_target <= '0;
    end else begin
      update_valid <= cm_hit;
      if (cm_hit) begin
        update_pc     <= pc_q[cm_sel];
        update_taken  <= tk_q[cm_sel];
        update_target <= tg_q[cm_sel];
      end
    end
  end

endmodule

// File: tb/tb_branch_resolve_update.sv
// Bench for branch_resolve_update: ROB-indexed reference model
// feeding redirect/update scoreboards checked by a pulse monitor.
module tb_branch_resolve_update;

  logic        clk;
  logic        rst_n;
  logic        resolve_valid;
  logic        resolve_ready;
  logic [63:0] resolve_pc;
  logic [5:0]  resolve_rob_idx;
  logic        resolve_taken;
  logic [63:0] resolve_target;
  logic        pred_taken;
  logic [63:0] pred_target;
  logic [5:0]  rob_head;
  logic        commit_valid;
  logic [5:0]  commit_rob_idx;
  logic        redirect_valid;
  logic [63:0] redirect_pc;
  logic [5:0]  redirect_rob_idx;
  logic        update_valid;
  logic [63:0] update_pc;
  logic        update_taken;
  logic [63:0] update_target;
  logic [3:0]  occupancy;
  logic [31:0] mispredict_cnt;

  branch_resolve_update #(.DEPTH(8), .ROB_IDX_W(6)) dut (
    .clk(clk), .rst_n(rst_n),
    .resolve_valid(resolve_valid), .resolve_ready(resolve_ready),
    .resolve_pc(resolve_pc), .resolve_rob_idx(resolve_rob_idx),
    .resolve_taken(resolve_taken), .resolve_target(resolve_target),
    .pred_taken(pred_taken), .pred_target(pred_target),
    .rob_head(rob_head),
    .commit_valid(commit_valid), .commit_rob_idx(commit_rob_idx),
    .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
    .redirect_rob_idx(redirect_rob_idx),
    .update_valid(update_valid), .update_pc(update_pc),
    .update_taken(update_taken), .update_target(update_target),
    .occupancy(occupancy), .mispredict_cnt(mispredict_cnt)
  );

  typedef struct {
    int          cyc;
    logic [63:0] pc;
    logic [5:0]  idx;
    logic [31:0] cnt;
  } redir_t;

  typedef struct {
    int          cyc;
    logic [63:0] pc;
    logic        tk;
    logic [63:0] tg;
  } upd_t;

  redir_t redir_q[$];
  upd_t   upd_q[$];

  int n_chk = 0;
  int n_err = 0;
  int cyc_n = 0;

  bit          m_v  [64];
  logic [63:0] m_pc [64];
  logic        m_tk [64];
  logic [63:0] m_tg [64];
  bit          m_fv;
  logic [5:0]  m_fi;
  logic [31:0] m_cnt;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc_n <= cyc_n + 1;

  task automatic chk(input string tag,
                     input logic [63:0] got,
                     input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got=%h exp=%h", tag, got, exp);
    end
  endtask

  function automatic int m_occ();
    int n = 0;
    for (int j = 0; j < 64; j++) n += int'(m_v[j]);
    return n;
  endfunction

  task automatic m_clear();
    for (int j = 0; j < 64; j++) m_v[j] = 1'b0;
    m_fv  = 1'b0;
    m_fi  = '0;
    m_cnt = '0;
    redir_q.delete();
    upd_q.delete();
  endtask

  // Pulse monitor: pops scoreboard entries when the DUT fires.
  always @(negedge clk) begin
    if (rst_n) begin
      if (redirect_valid) begin
        if (redir_q.size() == 0) begin
          chk("redir_spurious", 64'd1, 64'd0);
        end else begin
          redir_t e;
          e = redir_q.pop_front();
          chk("redir_cyc", 64'(cyc_n), 64'(e.cyc));
          chk("redir_pc", redirect_pc, e.pc);
          chk("redir_idx", 64'(redirect_rob_idx), 64'(e.idx));
          chk("redir_cnt", 64'(mispredict_cnt), 64'(e.cnt));
        end
      end
      if (update_valid) begin
        if (upd_q.size() == 0) begin
          chk("upd_spurious", 64'd1, 64'd0);
        end else begin
          upd_t u;
          u = upd_q.pop_front();
          chk("upd_cyc", 64'(cyc_n), 64'(u.cyc));
          chk("upd_pc", update_pc, u.pc);
          chk("upd_tk", 64'(update_taken), 64'(u.tk));
          chk("upd_tg", update_target, u.tg);
        end
      end
    end
  end

  task automatic cyc(input bit rv, input logic [63:0] pc,
                     input logic [5:0] idx, input bit tk,
                     input logic [63:0] tg, input bit ptk,
                     input logic [63:0] ptg, input bit cv,
                     input logic [5:0] cidx);
    logic [5:0] ra, fa, ja;
    bit acc, fenced, mp, fv0;
    int occ;
    resolve_valid   = rv;
    resolve_pc      = pc;
    resolve_rob_idx = idx;
    resolve_taken   = tk;
    resolve_target  = tg;
    pred_taken      = ptk;
    pred_target     = ptg;
    commit_valid    = cv;
    commit_rob_idx  = cidx;
    occ = m_occ();
    if (rv) chk("ready", 64'(resolve_ready), 64'(occ < 8));
    acc = rv && (occ < 8);
    fv0 = m_fv;
    if (cv && m_v[cidx]) begin
      upd_q.push_back('{cyc_n + 1, m_pc[cidx], m_tk[cidx], m_tg[cidx]});
      m_v[cidx] = 1'b0;
    end
    if (cv && m_fv && cidx == m_fi) m_fv = 1'b0;
    ra = idx - rob_head;
    fa = m_fi - rob_head;
    fenced = fv0 && (ra > fa);
    if (acc && !fenced) begin
      mp = (tk != ptk) || (tk && tg != ptg);
      if (mp) begin
        for (int j = 0; j < 64; j++) begin
          ja = 6'(j) - rob_head;
          if (m_v[j] && ja > ra) m_v[j] = 1'b0;
        end
        m_cnt = m_cnt + 32'd1;
        m_fv  = 1'b1;
        m_fi  = idx;
        redir_q.push_back('{cyc_n + 1, tk ? tg : pc + 64'd4, idx, m_cnt});
      end
      m_v[idx]  = 1'b1;
      m_pc[idx] = pc;
      m_tk[idx] = tk;
      m_tg[idx] = tg;
    end
    @(posedge clk);
    #1;
    resolve_valid = 1'b0;
    commit_valid  = 1'b0;
    chk("occ", 64'(occupancy), 64'(m_occ()));
  endtask

  task automatic res(input logic [63:0] pc, input logic [5:0] idx,
                     input bit tk, input logic [63:0] tg,
                     input bit ptk, input logic [63:0] ptg);
    cyc(1'b1, pc, idx, tk, tg, ptk, ptg, 1'b0, 6'd0);
  endtask

  task automatic com(input logic [5:0] idx);
    cyc(1'b0, 64'd0, 6'd0, 1'b0, 64'd0, 1'b0, 64'd0, 1'b1, idx);
  endtask

  task automatic idle(input int n);
    for (int k = 0; k < n; k++) begin
      cyc(1'b0, 64'd0, 6'd0, 1'b0, 64'd0, 1'b0, 64'd0, 1'b0, 6'd0);
    end
  endtask

  initial begin
    rst_n = 1'b0;
    resolve_valid = 1'b0;
    resolve_pc = '0;
    resolve_rob_idx = '0;
    resolve_taken = 1'b0;
    resolve_target = '0;
    pred_taken = 1'b0;
    pred_target = '0;
    rob_head = '0;
    commit_valid = 1'b0;
    commit_rob_idx = '0;
    m_clear();
    repeat (3) @(posedge clk);
    #1;
    chk("rst_occ", 64'(occupancy), 64'd0);
    chk("rst_ready", 64'(resolve_ready), 64'd1);
    chk("rst_redir", 64'(redirect_valid), 64'd0);
    chk("rst_upd", 64'(update_valid), 64'd0);
    chk("rst_cnt", 64'(mispredict_cnt), 64'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    // Correct not-taken branch trains at commit, no redirect.
    rob_head = 6'd0;
    res(64'h100, 6'd3, 1'b0, 64'h0, 1'b0, 64'h0);
    com(6'd3);
    idle(1);

    // Direction mispredicts in both senses.
    res(64'h200, 6'd5, 1'b1, 64'h400, 1'b0, 64'h0);
    com(6'd5);
    res(64'h200, 6'd6, 1'b0, 64'h0, 1'b1, 64'h300);
    com(6'd6);
    // Target mispredict with matching direction.
    res(64'h280, 6'd7, 1'b1, 64'h500, 1'b1, 64'h504);
    com(6'd7);
    idle(1);

    // Younger squash, fence discard, fence clear on commit.
    rob_head = 6'd4;
    res(64'h1060, 6'd6, 1'b0, 64'h0, 1'b0, 64'h0);
    res(64'h1090, 6'd9, 1'b1, 64'h2000, 1'b1, 64'h2000);
    res(64'h1070, 6'd7, 1'b1, 64'h3000, 1'b0, 64'h0);
    res(64'h1080, 6'd8, 1'b0, 64'h0, 1'b0, 64'h0);
    com(6'd6);
    com(6'd9);
    // Resolve and commit in the same cycle.
    cyc(1'b1, 64'h1080, 6'd8, 1'b0, 64'h0, 1'b0, 64'h0, 1'b1, 6'd7);
    com(6'd8);
    idle(1);

    // Fill to capacity, backpressure, and slot reuse.
    rob_head = 6'd10;
    for (int k = 0; k < 8; k++) begin
      res(64'h4000 + 64'(k * 4), 6'(10 + k), 1'b0, 64'h0, 1'b0, 64'h0);
    end
    chk("full_ready", 64'(resolve_ready), 64'd0);
    cyc(1'b1, 64'h4020, 6'd18, 1'b0, 64'h0, 1'b0, 64'h0, 1'b1, 6'd10);
    chk("freed_ready", 64'(resolve_ready), 64'd1);
    res(64'h4020, 6'd18, 1'b1, 64'h4800, 1'b1, 64'h4800);
    for (int k = 11; k <= 18; k++) com(6'(k));
    idle(1);

    // ROB index wrap-around ordering.
    rob_head = 6'd62;
    res(64'h5000, 6'd63, 1'b0, 64'h0, 1'b0, 64'h0);
    res(64'h5008, 6'd2, 1'b0, 64'h0, 1'b0, 64'h0);
    res(64'h5004, 6'd1, 1'b0, 64'h0, 1'b1, 64'h6000);
    com(6'd63);
    com(6'd2);
    com(6'd1);
    res(64'h5008, 6'd2, 1'b0, 64'h0, 1'b0, 64'h0);
    com(6'd2);
    idle(2);
    chk("redir_drain", 64'(redir_q.size()), 64'd0);
    chk("upd_drain", 64'(upd_q.size()), 64'd0);
    chk("cnt_final", 64'(mispredict_cnt), 64'(m_cnt));

    // Reset in the middle of traffic with pulses pending.
    rob_head = 6'd20;
    res(64'h7000, 6'd20, 1'b0, 64'h0, 1'b0, 64'h0);
    res(64'h7004, 6'd21, 1'b0, 64'h0, 1'b0, 64'h0);
    resolve_valid   = 1'b1;
    resolve_pc      = 64'h7008;
    resolve_rob_idx = 6'd22;
    resolve_taken   = 1'b1;
    resolve_target  = 64'h9000;
    pred_taken      = 1'b0;
    commit_valid    = 1'b1;
    commit_rob_idx  = 6'd20;
    #2;
    rst_n = 1'b0;
    #1;
    m_clear();
    chk("mid_rst_occ", 64'(occupancy), 64'd0);
    @(posedge clk);
    #1;
    resolve_valid = 1'b0;
    commit_valid  = 1'b0;
    chk("mid_rst_redir", 64'(redirect_valid), 64'd0);
    chk("mid_rst_upd", 64'(update_valid), 64'd0);
    chk("mid_rst_cnt", 64'(mispredict_cnt), 64'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    idle(3);
    chk("post_rst_occ", 64'(occupancy), 64'd0);
    chk("post_rst_redir_q", 64'(redir_q.size()), 64'd0);
    chk("post_rst_upd_q", 64'(upd_q.size()), 64'd0);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
